// File: rtl/dmem_arbiter.sv
// Arbitrates the single data_mem port between the CPU (fixed priority) and the host (bounded wait).
// Optional grant/stall statistics counters are enabled with `define DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  input  logic          stats_clr,
  output logic [15:0]   cpu_gnt_ct,
  output logic [15:0]   host_gnt_ct,
  output logic [15:0]   host_stall_ct
`endif
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [3:0] wait_ct;
  logic [3:0] wait_ct_nxt;
  logic       force_host;
  logic       cpu_rd_gnt;
  logic       host_rd_gnt;

  // A host that has been refused MAX_WAIT times in a row overrides CPU priority.
  always_comb begin
    force_host = host_req && (wait_ct == MAX_W);
    cpu_gnt    = 1'b0;
    host_gnt   = 1'b0;
    if (force_host) begin
      host_gnt = 1'b1;
    end else if (cpu_req) begin
      cpu_gnt = 1'b1;
    end else if (host_req) begin
      host_gnt = 1'b1;
    end
  end

  // With no grant the CPU fields sit on the bus but writes stay disabled.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_wr_en = 1'b0;
    if (host_gnt) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_wr_en = host_we;
    end else if (cpu_gnt) begin
      mem_wr_en = cpu_we;
    end
  end

  always_comb begin
    wait_ct_nxt = wait_ct;
    if (!host_req || host_gnt) begin
      wait_ct_nxt = 4'd0;
    end else if (wait_ct < MAX_W) begin
      wait_ct_nxt = wait_ct + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      wait_ct <= 4'd0;
    end else begin
      wait_ct <= wait_ct_nxt;
    end
  end

  assign cpu_rd_gnt  = cpu_gnt && !cpu_we;
  assign host_rd_gnt = host_gnt && !host_we;

  // Read data is captured at the grant edge and held until the next read grant.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      cpu_rvalid <= cpu_rd_gnt;
      if (cpu_rd_gnt) begin
        cpu_rdata <= mem_rdata;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      host_rvalid <= host_rd_gnt;
      if (host_rd_gnt) begin
        host_rdata <= mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic host_stall;
  assign host_stall = host_req && !host_gnt;

  // Saturating counters; a clear in the same cycle as an increment wins.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      cpu_gnt_ct    <= 16'd0;
      host_gnt_ct   <= 16'd0;
      host_stall_ct <= 16'd0;
    end else if (stats_clr) begin
      cpu_gnt_ct    <= 16'd0;
      host_gnt_ct   <= 16'd0;
      host_stall_ct <= 16'd0;
    end else begin
      if (cpu_gnt && (cpu_gnt_ct != 16'hFFFF)) begin
        cpu_gnt_ct <= cpu_gnt_ct + 16'd1;
      end
      if (host_gnt && (host_gnt_ct != 16'hFFFF)) begin
        host_gnt_ct <= host_gnt_ct + 16'd1;
      end
      if (host_stall && (host_stall_ct != 16'hFFFF)) begin
        host_stall_ct <= host_stall_ct + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised bench for dmem_arbiter: grant checks per cycle, read data via a scoreboard queue per requester.
module tb_dmem_arbiter;
  localparam int MAX_WAIT = 4;

  logic       CLK = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0;
  logic       cpu_gnt, cpu_rvalid;
  logic [7:0] cpu_rdata;
  logic       host_req = 1'b0, host_we = 1'b0;
  logic [7:0] host_addr = '0, host_wdata = '0;
  logic       host_gnt, host_rvalid;
  logic [7:0] host_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_wr_en;
`ifdef DMEM_ARB_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] cpu_gnt_ct, host_gnt_ct, host_stall_ct;
`endif

  dmem_arbiter #(.AW(8), .DW(8), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stats_clr(stats_clr), .cpu_gnt_ct(cpu_gnt_ct), .host_gnt_ct(host_gnt_ct),
    .host_stall_ct(host_stall_ct)
`endif
  );

  always #5 CLK = ~CLK;

  // data_mem: combinational read, write at the clock edge
  logic [7:0] phys_mem [256];
  initial for (int i = 0; i < 256; i++) phys_mem[i] = 8'h00;
  always @(posedge CLK) if (mem_wr_en) phys_mem[mem_addr] <= mem_wdata;
  assign mem_rdata = phys_mem[mem_addr];

  typedef struct { logic [7:0] d; int cyc; } exp_t;
  exp_t cpu_q[$];
  exp_t host_q[$];

  logic [7:0] ref_mem [256];
  int  host_denied = 0;
  bit  cpu_pend = 0, host_pend = 0;
  logic [7:0] last_cpu = 8'h00, last_host = 8'h00;
  int  cyc = 0;
  int  errors = 0, checks = 0;

  always @(posedge CLK) cyc++;

  function automatic void chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Reference: CPU wins unless the host has already been refused MAX_WAIT cycles in a row.
  task automatic eval_cycle();
    bit force_h, eh, ec, ewe;
    force_h = host_req && (host_denied == MAX_WAIT);
    eh = host_req && (force_h || !cpu_req);
    ec = cpu_req && !force_h;
    ewe = (ec && cpu_we) || (eh && host_we);
    chk("cpu_gnt", cpu_gnt, ec);
    chk("host_gnt", host_gnt, eh);
    chk("mem_wr_en", mem_wr_en, ewe);
    chk("mem_addr", mem_addr, eh ? host_addr : cpu_addr);
    if (ewe) chk("mem_wdata", mem_wdata, eh ? host_wdata : cpu_wdata);
    if (ec) begin
      if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
      else cpu_q.push_back('{ref_mem[cpu_addr], cyc});
    end
    if (eh) begin
      if (host_we) ref_mem[host_addr] = host_wdata;
      else host_q.push_back('{ref_mem[host_addr], cyc});
    end
    host_denied = (host_req && !eh) ? host_denied + 1 : 0;
    cpu_pend  = cpu_req && !ec;
    host_pend = host_req && !eh;
  endtask

  task automatic step(input bit cr, input bit cw, input logic [7:0] ca, input logic [7:0] cd,
                      input bit hr, input bit hw, input logic [7:0] ha, input logic [7:0] hd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    #1 eval_cycle();
    @(negedge CLK);
  endtask

  task automatic model_reset();
    cpu_q.delete(); host_q.delete();
    host_denied = 0; cpu_pend = 0; host_pend = 0;
    last_cpu = 8'h00; last_host = 8'h00;
  endtask

  // Monitor: rvalid must appear exactly one cycle after a read grant, with the modelled data.
  initial forever begin
    bit ev;
    @(posedge CLK); #1;
    if (reset_n) begin
      while (cpu_q.size() > 0 && cpu_q[0].cyc < cyc - 1) begin
        chk("cpu_rvalid_late", 0, 1); void'(cpu_q.pop_front());
      end
      ev = (cpu_q.size() > 0 && cpu_q[0].cyc == cyc - 1);
      chk("cpu_rvalid", cpu_rvalid, ev);
      if (ev) last_cpu = cpu_q.pop_front().d;
      chk("cpu_rdata", cpu_rdata, last_cpu);
      while (host_q.size() > 0 && host_q[0].cyc < cyc - 1) begin
        chk("host_rvalid_late", 0, 1); void'(host_q.pop_front());
      end
      ev = (host_q.size() > 0 && host_q[0].cyc == cyc - 1);
      chk("host_rvalid", host_rvalid, ev);
      if (ev) last_host = host_q.pop_front().d;
      chk("host_rdata", host_rdata, last_host);
    end
  end

  initial begin
    bit cr, cw, hr, hw;
    logic [7:0] ca, cd, ha, hd;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    cr = 0; cw = 0; hr = 0; hw = 0; ca = 0; cd = 0; ha = 0; hd = 0;

    // reset then idle
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_cpu_gnt", cpu_gnt, 0);   chk("rst_host_gnt", host_gnt, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0); chk("rst_host_rvalid", host_rvalid, 0);
    chk("rst_mem_wr_en", mem_wr_en, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0); chk("rst_host_rdata", host_rdata, 0);
`ifdef DMEM_ARB_STATS_EN
    chk("rst_cpu_gnt_ct", cpu_gnt_ct, 0); chk("rst_host_gnt_ct", host_gnt_ct, 0);
    chk("rst_host_stall_ct", host_stall_ct, 0);
`endif
    @(negedge CLK);
    reset_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // host preload then readback
    step(0, 0, 0, 0, 1, 1, 8'd9, 8'hA5);
    step(0, 0, 0, 0, 1, 0, 8'd9, 8'h00);
    chk("preload_rdata", host_rdata, 8'hA5);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // contention: host every (MAX_WAIT+1)th cycle
`ifdef DMEM_ARB_STATS_EN
    stats_clr = 1'b1;
`endif
    step(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef DMEM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    for (int i = 0; i < 10; i++) begin
      cr = 1; cw = 0; ca = 8'd9; hr = 1; hw = 0; ha = 8'd9;
      #1;
      chk("contend_host_gnt", host_gnt, (i % 5) == 4);
      #0 step(cr, cw, ca, 0, hr, hw, ha, 0);
    end
`ifdef DMEM_ARB_STATS_EN
    chk("stats_cpu_gnt_ct", cpu_gnt_ct, 8);
    chk("stats_host_gnt_ct", host_gnt_ct, 2);
    chk("stats_host_stall_ct", host_stall_ct, 8);
    stats_clr = 1'b1;
    step(1, 0, 8'd1, 0, 1, 0, 8'd2, 0);
    stats_clr = 1'b0;
    chk("clr_cpu_gnt_ct", cpu_gnt_ct, 0); chk("clr_host_gnt_ct", host_gnt_ct, 0);
    chk("clr_host_stall_ct", host_stall_ct, 0);
`endif
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // back-to-back CPU write then read of the same address
    step(1, 1, 8'd32, 8'h3C, 0, 0, 0, 0);
    step(1, 0, 8'd32, 8'h00, 0, 0, 0, 0);
    chk("b2b_cpu_rdata", cpu_rdata, 8'h3C);

    // reset pulse in the cycle after a CPU read grant
    reset_n = 1'b0;
    cpu_req = 0; host_req = 0;
    #1;
    chk("midrst_cpu_rvalid", cpu_rvalid, 0);
    chk("midrst_cpu_rdata", cpu_rdata, 0);
    chk("midrst_host_rdata", host_rdata, 0);
    model_reset();
    @(negedge CLK);
    reset_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // random traffic, fields held while a request waits
    for (int n = 0; n < 600; n++) begin
      if (!cpu_pend) begin
        cr = ($urandom_range(0, 9) < 7); cw = $urandom_range(0, 1);
        ca = 8'($urandom_range(0, 7)); cd = 8'($urandom);
      end
      if (!host_pend) begin
        hr = ($urandom_range(0, 9) < 6); hw = $urandom_range(0, 1);
        ha = 8'($urandom_range(0, 7)); hd = 8'($urandom);
      end
      step(cr, cw, ca, cd, hr, hw, ha, hd);
    end

    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("host_q_drained", host_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end
endmodule
